// File: rtl/exc_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : exc_commit_ctrl
//  Description : MEM-stage exception/interrupt commit controller. Synchronises
//                hardware interrupts, prioritises the exception sources of the
//                MEM-stage instruction, registers the winner, pulses the CP0
//                commit strobes and holds a multi-cycle flush with PC redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_commit_ctrl #(
    parameter int          NUM_HW_INT   = 6,
    parameter int          SYNC_STAGES  = 2,
    parameter int          FLUSH_CYCLES = 1,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_m,
    input  logic [31:0]           pc_m,
    input  logic                  bd_m,
    input  logic [7:0]            except_m,
    input  logic                  adel_m,
    input  logic                  ades_m,
    input  logic [31:0]           badaddr_m,
    input  logic [NUM_HW_INT-1:0] hw_int,
    input  logic [31:0]           cp0_status,
    input  logic [31:0]           cp0_cause,
    input  logic [31:0]           cp0_epc,
    output logic [NUM_HW_INT-1:0] int_pending,
    output logic [31:0]           excepttype,
    output logic                  exc_commit,
    output logic                  eret_commit,
    output logic [31:0]           epc_o,
    output logic                  bd_o,
    output logic [4:0]            exccode_o,
    output logic                  badvaddr_we,
    output logic [31:0]           badvaddr_o,
    output logic                  flush,
    output logic [31:0]           new_pc
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_FLUSH = 1'b1;

    localparam int         c_IPW      = NUM_HW_INT + 2;
    localparam logic [2:0] c_CNT_INIT = 3'(FLUSH_CYCLES - 1);

    localparam logic [4:0] c_EXC_NONE = 5'h00;
    localparam logic [4:0] c_EXC_INT  = 5'h01;
    localparam logic [4:0] c_EXC_ADEL = 5'h04;
    localparam logic [4:0] c_EXC_ADES = 5'h05;
    localparam logic [4:0] c_EXC_SYS  = 5'h08;
    localparam logic [4:0] c_EXC_BP   = 5'h09;
    localparam logic [4:0] c_EXC_RI   = 5'h0a;
    localparam logic [4:0] c_EXC_OV   = 5'h0c;
    localparam logic [4:0] c_EXC_ERET = 5'h0e;

    logic [NUM_HW_INT-1:0] r_sync [SYNC_STAGES];
    logic [0:0]            r_state;
    logic [2:0]            r_cnt;

    logic [c_IPW-1:0] w_ip_lines;
    logic             w_int;
    logic [4:0]       w_code;
    logic             w_addr_err;
    logic [31:0]      w_bva;
    logic [31:0]      w_epc;
    logic             w_fire;
    logic             w_unused;

    // Bits of the CP0 words and except_m that play no part in the decision.
    assign w_unused = &{1'b0, cp0_status, cp0_cause, except_m[1:0]};

    // Multi-flop synchroniser on every asynchronous interrupt line.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
        end else begin
            r_sync[0] <= hw_int;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign int_pending = r_sync[SYNC_STAGES-1];

    // Interrupt qualifies only on a real instruction with IE set and EXL clear.
    assign w_ip_lines = {int_pending, cp0_cause[9:8]};
    assign w_int      = valid_m && cp0_status[0] && !cp0_status[1] &&
                        (|(w_ip_lines & cp0_status[8 +: c_IPW]));

    // Wrap-around is intended: a delay slot at address 0 reports 0xFFFFFFFC.
    assign w_epc = bd_m ? (pc_m - 32'd4) : pc_m;

    // Fixed-priority selection of the cause to commit.
    always_comb begin
        w_code     = c_EXC_NONE;
        w_addr_err = 1'b0;
        w_bva      = badaddr_m;
        if (w_int) begin
            w_code = c_EXC_INT;
        end else if (valid_m) begin
            if (except_m[7] || adel_m) begin
                w_code     = c_EXC_ADEL;
                w_addr_err = 1'b1;
                // A fetch fault reports the instruction address itself.
                w_bva      = except_m[7] ? pc_m : badaddr_m;
            end else if (ades_m) begin
                w_code     = c_EXC_ADES;
                w_addr_err = 1'b1;
            end else if (except_m[6]) begin
                w_code = c_EXC_SYS;
            end else if (except_m[5]) begin
                w_code = c_EXC_BP;
            end else if (except_m[4]) begin
                w_code = c_EXC_ERET;
            end else if (except_m[3]) begin
                w_code = c_EXC_RI;
            end else if (except_m[2]) begin
                w_code = c_EXC_OV;
            end
        end
    end

    assign w_fire = (r_state == S_IDLE) && (w_code != c_EXC_NONE);

    // Commit FSM: capture on detection, then hold the flush for FLUSH_CYCLES.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            excepttype  <= 32'd0;
            epc_o       <= 32'd0;
            bd_o        <= 1'b0;
            badvaddr_o  <= 32'd0;
            badvaddr_we <= 1'b0;
            exc_commit  <= 1'b0;
            eret_commit <= 1'b0;
            flush       <= 1'b0;
            new_pc      <= 32'd0;
        end else begin
            exc_commit  <= 1'b0;
            eret_commit <= 1'b0;
            badvaddr_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fire) begin
                        r_state     <= S_FLUSH;
                        r_cnt       <= c_CNT_INIT;
                        excepttype  <= {27'd0, w_code};
                        epc_o       <= w_epc;
                        bd_o        <= bd_m;
                        flush       <= 1'b1;
                        new_pc      <= (w_code == c_EXC_ERET) ? cp0_epc : EXC_VECTOR;
                        exc_commit  <= (w_code != c_EXC_ERET);
                        eret_commit <= (w_code == c_EXC_ERET);
                        if (w_addr_err) begin
                            badvaddr_o  <= w_bva;
                            badvaddr_we <= 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_cnt == 3'd0) begin
                        r_state    <= S_IDLE;
                        flush      <= 1'b0;
                        excepttype <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign exccode_o = excepttype[4:0];

endmodule
`default_nettype wire

// File: tb/tb_exc_commit_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exc_commit_ctrl
//  Description : Self-checking bench for exc_commit_ctrl: directed scenarios
//                followed by random traffic against a cycle-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exc_commit_ctrl;

    localparam int          NHW = 6;
    localparam int          SS  = 2;
    localparam int          FC  = 3;
    localparam logic [31:0] VEC = 32'hBFC00380;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           valid_m;
    logic [31:0]    pc_m;
    logic           bd_m;
    logic [7:0]     except_m;
    logic           adel_m;
    logic           ades_m;
    logic [31:0]    badaddr_m;
    logic [NHW-1:0] hw_int;
    logic [31:0]    cp0_status;
    logic [31:0]    cp0_cause;
    logic [31:0]    cp0_epc;
    logic [NHW-1:0] int_pending;
    logic [31:0]    excepttype;
    logic           exc_commit;
    logic           eret_commit;
    logic [31:0]    epc_o;
    logic           bd_o;
    logic [4:0]     exccode_o;
    logic           badvaddr_we;
    logic [31:0]    badvaddr_o;
    logic           flush;
    logic [31:0]    new_pc;

    exc_commit_ctrl #(
        .NUM_HW_INT  (NHW),
        .SYNC_STAGES (SS),
        .FLUSH_CYCLES(FC),
        .EXC_VECTOR  (VEC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_m    (valid_m),
        .pc_m       (pc_m),
        .bd_m       (bd_m),
        .except_m   (except_m),
        .adel_m     (adel_m),
        .ades_m     (ades_m),
        .badaddr_m  (badaddr_m),
        .hw_int     (hw_int),
        .cp0_status (cp0_status),
        .cp0_cause  (cp0_cause),
        .cp0_epc    (cp0_epc),
        .int_pending(int_pending),
        .excepttype (excepttype),
        .exc_commit (exc_commit),
        .eret_commit(eret_commit),
        .epc_o      (epc_o),
        .bd_o       (bd_o),
        .exccode_o  (exccode_o),
        .badvaddr_we(badvaddr_we),
        .badvaddr_o (badvaddr_o),
        .flush      (flush),
        .new_pc     (new_pc)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: interrupt delay line, remaining flush cycles, expected outputs.
    logic [NHW-1:0] hq[$];
    logic [NHW-1:0] m_pend;
    int             m_left;
    logic [31:0]    e_type, e_epc, e_bva, e_newpc;
    logic           e_bd, e_bvwe, e_exc, e_eret, e_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural cause selection for the current inputs.
    function automatic logic [31:0] ev_code(input logic [NHW-1:0] pend);
        logic [7:0] lines;
        lines = {pend, cp0_cause[9:8]};
        if (valid_m && cp0_status[0] && !cp0_status[1] && ((lines & cp0_status[15:8]) != 8'd0))
            return 32'h1;
        if (!valid_m)                return 32'h0;
        if (except_m[7] || adel_m)   return 32'h4;
        if (ades_m)                  return 32'h5;
        if (except_m[6])             return 32'h8;
        if (except_m[5])             return 32'h9;
        if (except_m[4])             return 32'he;
        if (except_m[3])             return 32'ha;
        if (except_m[2])             return 32'hc;
        return 32'h0;
    endfunction

    task automatic model_reset();
        hq.delete();
        for (int i = 0; i < SS; i++) hq.push_back('0);
        m_pend = '0; m_left = 0;
        e_type = 0; e_epc = 0; e_bva = 0; e_newpc = 0;
        e_bd = 0; e_bvwe = 0; e_exc = 0; e_eret = 0; e_flush = 0;
    endtask

    // Advance the reference by one clock edge using the inputs sampled at it.
    task automatic model_edge();
        logic [31:0] code;
        if (rst) begin
            model_reset();
        end else begin
            code   = ev_code(m_pend);
            e_exc  = 0; e_eret = 0; e_bvwe = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    e_flush = 0;
                    e_type  = 0;
                end
            end else if (code != 0) begin
                e_type  = code;
                e_epc   = bd_m ? pc_m - 32'd4 : pc_m;
                e_bd    = bd_m;
                e_flush = 1;
                e_newpc = (code == 32'he) ? cp0_epc : VEC;
                e_exc   = (code != 32'he);
                e_eret  = (code == 32'he);
                if (code == 32'h4 || code == 32'h5) begin
                    e_bvwe = 1;
                    e_bva  = (code == 32'h4 && except_m[7]) ? pc_m : badaddr_m;
                end
                m_left = FC;
            end
            hq.push_back(hw_int);
            void'(hq.pop_front());
            m_pend = hq[0];
        end
    endtask

    task automatic compare_all();
        chk("int_pending", 32'(int_pending), 32'(m_pend));
        chk("excepttype", excepttype, e_type);
        chk("exc_commit", 32'(exc_commit), 32'(e_exc));
        chk("eret_commit", 32'(eret_commit), 32'(e_eret));
        chk("badvaddr_we", 32'(badvaddr_we), 32'(e_bvwe));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("exccode_o", 32'(exccode_o), {27'd0, e_type[4:0]});
        if (e_flush) begin
            chk("new_pc", new_pc, e_newpc);
            chk("epc_o", epc_o, e_epc);
            chk("bd_o", 32'(bd_o), 32'(e_bd));
        end
        if (e_bvwe) chk("badvaddr_o", badvaddr_o, e_bva);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic quiet();
        valid_m = 0; pc_m = 0; bd_m = 0; except_m = 0; adel_m = 0; ades_m = 0;
        badaddr_m = 0; cp0_cause = 0; cp0_epc = 0;
    endtask

    initial begin
        model_reset();
        quiet();
        hw_int = '0; cp0_status = 0; rst = 1;
        run(2);
        chk("reset_flush", 32'(flush), 32'h0);
        chk("reset_type", excepttype, 32'h0);
        rst = 0;
        run(1);

        // Hardware interrupt on line 0 through the synchroniser.
        cp0_status = 32'h0000_0401; valid_m = 1; pc_m = 32'h8000_0100; hw_int = 6'b000001;
        run(1);
        chk("sync_not_yet", 32'(int_pending[0]), 32'h0);
        run(1);
        chk("sync_two_clks", 32'(int_pending[0]), 32'h1);
        run(1);
        chk("int_type", excepttype, 32'h1);
        chk("int_commit", 32'(exc_commit), 32'h1);
        chk("int_newpc", new_pc, VEC);
        hw_int = '0; valid_m = 0;
        run(1);
        chk("int_strobe_once", 32'(exc_commit), 32'h0);
        run(FC + 1);

        // Load address error beats syscall.
        cp0_status = 0; valid_m = 1; adel_m = 1; except_m = 8'h40;
        pc_m = 32'h8000_1000; badaddr_m = 32'h1235;
        run(1);
        chk("adel_type", excepttype, 32'h4);
        chk("adel_bva", badvaddr_o, 32'h1235);
        chk("adel_we", 32'(badvaddr_we), 32'h1);
        quiet(); run(FC + 1);

        // eret redirects to EPC without an exception commit.
        valid_m = 1; except_m = 8'h10; cp0_epc = 32'h8000_2000;
        run(1);
        chk("eret_type", excepttype, 32'he);
        chk("eret_strobe", 32'(eret_commit), 32'h1);
        chk("eret_no_exc", 32'(exc_commit), 32'h0);
        chk("eret_newpc", new_pc, 32'h8000_2000);
        quiet(); run(FC + 1);

        // Overflow in a delay slot.
        valid_m = 1; bd_m = 1; pc_m = 32'h8000_0010; except_m = 8'h04;
        run(1);
        chk("ov_type", excepttype, 32'hc);
        chk("ov_epc", epc_o, 32'h8000_000C);
        chk("ov_bd", 32'(bd_o), 32'h1);
        quiet(); run(FC + 1);

        // Break held through the whole flush: exactly FC flush cycles, one commit.
        valid_m = 1; except_m = 8'h20;
        run(1);
        chk("bp_commit", 32'(exc_commit), 32'h1);
        run(FC - 1);
        chk("bp_flush_last", 32'(flush), 32'h1);
        chk("bp_no_recommit", 32'(exc_commit), 32'h0);
        quiet();
        run(1);
        chk("bp_flush_end", 32'(flush), 32'h0);
        run(1);

        // Reset during the second flush cycle.
        valid_m = 1; except_m = 8'h20;
        run(2);
        rst = 1;
        run(1);
        chk("rst_mid_flush", 32'(flush), 32'h0);
        chk("rst_no_strobe", 32'(exc_commit), 32'h0);
        rst = 0; quiet();
        run(1);

        // Pending interrupt masked by IE=0, then by EXL=1.
        hw_int = 6'b000001; valid_m = 1; cp0_status = 32'h0000_0400;
        run(4);
        chk("ie0_no_flush", 32'(flush), 32'h0);
        cp0_status = 32'h0000_0403;
        run(3);
        chk("exl1_no_flush", 32'(flush), 32'h0);
        hw_int = '0; quiet(); cp0_status = 0;
        run(3);

        // EPC wrap-around.
        valid_m = 1; bd_m = 1; pc_m = 32'h0; except_m = 8'h04;
        run(1);
        chk("epc_wrap", epc_o, 32'hFFFF_FFFC);
        quiet(); run(FC + 1);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            valid_m = ($urandom_range(7) != 0);
            except_m = '0;
            for (int b = 0; b < 8; b++) except_m[b] = ($urandom_range(15) == 0);
            adel_m    = ($urandom_range(19) == 0);
            ades_m    = ($urandom_range(19) == 0);
            pc_m      = $urandom & 32'hFFFF_FFFC;
            bd_m      = $urandom_range(1);
            badaddr_m = $urandom;
            cp0_epc   = $urandom;
            cp0_cause = ($urandom_range(9) == 0) ? $urandom : 32'h0;
            if ($urandom_range(9) == 0) hw_int = NHW'($urandom);
            cp0_status = {16'h0, 8'($urandom), 6'h0,
                          1'($urandom_range(5) == 0), 1'($urandom_range(5) != 0)};
            rst = ($urandom_range(199) == 0);
            step();
        end
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
